// File: rtl/patp_pkg.sv
// rtl/patp_pkg.sv - shared opcode, state and width definitions for the PATP core
// Purpose: opcode map, control-unit state encoding and instruction field widths.
// Ports: none (package).
package patp_pkg;

  localparam int OPC_W  = 3;
  localparam int OPND_W = 5;

  localparam logic [OPC_W-1:0] OP_CLR  = 3'b000;
  localparam logic [OPC_W-1:0] OP_INC  = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OPC_W-1:0] OP_DEC  = 3'b011;
  localparam logic [OPC_W-1:0] OP_JMP  = 3'b100;
  localparam logic [OPC_W-1:0] OP_BNZ  = 3'b101;
  localparam logic [OPC_W-1:0] OP_STA  = 3'b110;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FADDR  = 4'd1,
    S_FMEM   = 4'd2,
    S_DECODE = 4'd3,
    S_ADD    = 4'd4,
    S_STA    = 4'd5,
    S_HALT   = 4'd6,
    S_ERR    = 4'd7
  } state_t;

  // States that hold mem_req and therefore run the wait timer.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FMEM) || (s == S_ADD) || (s == S_STA);
  endfunction

endpackage

// File: rtl/patp_cu_wait_timer.sv
// rtl/patp_cu_wait_timer.sv - memory wait-cycle counter with timeout detect
// Purpose: counts cycles a request goes unacknowledged; flags when the limit is reached.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   i_clr       hold counter at zero (outside memory states)
//   i_tick      one more cycle without ack
//   o_expired   counter equals TIMEOUT_CYCLES (never set when TIMEOUT_CYCLES == 0)
module patp_cu_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TMR_W          = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_expired
);

  localparam logic [TMR_W-1:0] LIMIT   = TMR_W'(TIMEOUT_CYCLES);
  localparam logic             TMR_ENA = (TIMEOUT_CYCLES != 0);

  logic [TMR_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == LIMIT);
  assign o_expired  = TMR_ENA && w_at_limit;

  // Stops at the limit so a late tick can never wrap the count back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || !TMR_ENA) begin
      r_cnt <= '0;
    end else if (i_tick && !w_at_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/patp_control_unit.sv
// rtl/patp_control_unit.sv - multi-cycle control FSM of the PATP core
// Purpose: fetch/decode/execute sequencing with req/ack memory handshake and bus timeout.
// Optional: define PATP_CU_RETIRE_CNT_EN to add the o_retired_cnt instruction counter.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_opcode[2:0]            registered opcode from IR (valid the cycle after o_ir_we)
//   i_z_flag                 accumulator == 0
//   i_mem_ack                memory completes the access this cycle
//   o_mem_req, o_mem_we      memory request and write qualifier
//   o_mar_we, o_mar_sel      MAR load, source 0 = PC / 1 = IR operand
//   o_ir_we                  IR load from memory data
//   o_pc_inc, o_pc_load      PC increment / load from IR operand
//   o_acc_clr/inc/dec/add    accumulator operations
//   o_halted, o_bus_err      terminal status (cleared only by rst)
//   o_retired_cnt[15:0]      completed instructions (PATP_CU_RETIRE_CNT_EN only)
module patp_control_unit
  import patp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TMR_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_z_flag,
  input  logic             i_mem_ack,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_mar_we,
  output logic             o_mar_sel,
  output logic             o_ir_we,
  output logic             o_pc_inc,
  output logic             o_pc_load,
  output logic             o_acc_clr,
  output logic             o_acc_inc,
  output logic             o_acc_dec,
  output logic             o_acc_add,
  output logic             o_halted,
  output logic             o_bus_err
`ifdef PATP_CU_RETIRE_CNT_EN
  ,
  output logic [15:0]      o_retired_cnt
`endif
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_tmr_clr;
  logic   w_tmr_tick;
  logic   w_tmr_expired;

  // Counter is held clear everywhere except the request states, which clears it on entry.
  assign w_tmr_clr = !is_mem_state(r_state);

  patp_cu_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tmr_clr),
    .i_tick   (w_tmr_tick),
    .o_expired(w_tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs depend only on r_state, i_mem_ack, i_z_flag and (in DECODE) i_opcode,
  // so an asynchronous reset removes mem_req without waiting for a clock edge.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_tick  = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mar_we    = 1'b0;
    o_mar_sel   = 1'b0;
    o_ir_we     = 1'b0;
    o_pc_inc    = 1'b0;
    o_pc_load   = 1'b0;
    o_acc_clr   = 1'b0;
    o_acc_inc   = 1'b0;
    o_acc_dec   = 1'b0;
    o_acc_add   = 1'b0;
    o_halted    = 1'b0;
    o_bus_err   = 1'b0;

    case (r_state)
      S_RESET: w_state_nxt = S_FADDR;

      S_FADDR: begin
        o_mar_we    = 1'b1;
        w_state_nxt = S_FMEM;
      end

      // In every request state an ack in the limit cycle takes priority over the timeout.
      S_FMEM: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          o_ir_we     = 1'b1;
          o_pc_inc    = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (w_tmr_expired) begin
          w_state_nxt = S_ERR;
        end else begin
          w_tmr_tick = 1'b1;
        end
      end

      S_DECODE: begin
        w_state_nxt = S_FADDR;
        case (i_opcode)
          OP_CLR: o_acc_clr = 1'b1;
          OP_INC: o_acc_inc = 1'b1;
          OP_DEC: o_acc_dec = 1'b1;
          OP_JMP: o_pc_load = 1'b1;
          OP_BNZ: o_pc_load = ~i_z_flag;
          OP_ADD: begin
            o_mar_we    = 1'b1;
            o_mar_sel   = 1'b1;
            w_state_nxt = S_ADD;
          end
          OP_STA: begin
            o_mar_we    = 1'b1;
            o_mar_sel   = 1'b1;
            w_state_nxt = S_STA;
          end
          OP_HALT: w_state_nxt = S_HALT;
          default: w_state_nxt = S_FADDR;
        endcase
      end

      S_ADD: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          o_acc_add   = 1'b1;
          w_state_nxt = S_FADDR;
        end else if (w_tmr_expired) begin
          w_state_nxt = S_ERR;
        end else begin
          w_tmr_tick = 1'b1;
        end
      end

      S_STA: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        if (i_mem_ack) begin
          w_state_nxt = S_FADDR;
        end else if (w_tmr_expired) begin
          w_state_nxt = S_ERR;
        end else begin
          w_tmr_tick = 1'b1;
        end
      end

      S_HALT: o_halted = 1'b1;

      S_ERR: o_bus_err = 1'b1;

      default: w_state_nxt = S_RESET;
    endcase
  end

`ifdef PATP_CU_RETIRE_CNT_EN
  logic        w_retire;
  logic [15:0] r_retired_cnt;

  // Last cycle of an instruction: DECODE for everything except ADD/STA, whose
  // final cycle is the data-access ack.
  assign w_retire = ((r_state == S_DECODE) && (i_opcode != OP_ADD) && (i_opcode != OP_STA))
                 || (((r_state == S_ADD) || (r_state == S_STA)) && i_mem_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired_cnt <= '0;
    end else if (w_retire) begin
      r_retired_cnt <= r_retired_cnt + 16'd1;
    end
  end

  assign o_retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_patp_control_unit.sv
// tb/tb_patp_control_unit.sv - scoreboard testbench for patp_control_unit
module tb_patp_control_unit;
  import patp_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] i_opcode;
  logic       i_z_flag;
  logic       i_mem_ack;
  logic       o_mem_req, o_mem_we, o_mar_we, o_mar_sel, o_ir_we, o_pc_inc, o_pc_load;
  logic       o_acc_clr, o_acc_inc, o_acc_dec, o_acc_add, o_halted, o_bus_err;
`ifdef PATP_CU_RETIRE_CNT_EN
  logic [15:0] o_retired_cnt;
`endif

  always #5 clk = ~clk;

  patp_control_unit #(.TIMEOUT_CYCLES(15), .TMR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_opcode (i_opcode),
    .i_z_flag (i_z_flag),
    .i_mem_ack(i_mem_ack),
    .o_mem_req(o_mem_req),
    .o_mem_we (o_mem_we),
    .o_mar_we (o_mar_we),
    .o_mar_sel(o_mar_sel),
    .o_ir_we  (o_ir_we),
    .o_pc_inc (o_pc_inc),
    .o_pc_load(o_pc_load),
    .o_acc_clr(o_acc_clr),
    .o_acc_inc(o_acc_inc),
    .o_acc_dec(o_acc_dec),
    .o_acc_add(o_acc_add),
    .o_halted (o_halted),
    .o_bus_err(o_bus_err)
`ifdef PATP_CU_RETIRE_CNT_EN
    ,
    .o_retired_cnt(o_retired_cnt)
`endif
  );

  localparam logic [12:0] E_NONE    = 13'h0000;
  localparam logic [12:0] E_MEM_REQ = 13'h1000;
  localparam logic [12:0] E_MEM_WE  = 13'h0800;
  localparam logic [12:0] E_MAR_WE  = 13'h0400;
  localparam logic [12:0] E_MAR_SEL = 13'h0200;
  localparam logic [12:0] E_IR_WE   = 13'h0100;
  localparam logic [12:0] E_PC_INC  = 13'h0080;
  localparam logic [12:0] E_PC_LOAD = 13'h0040;
  localparam logic [12:0] E_ACC_CLR = 13'h0020;
  localparam logic [12:0] E_ACC_INC = 13'h0010;
  localparam logic [12:0] E_ACC_DEC = 13'h0008;
  localparam logic [12:0] E_ACC_ADD = 13'h0004;
  localparam logic [12:0] E_HALTED  = 13'h0002;
  localparam logic [12:0] E_BUS_ERR = 13'h0001;

  logic [12:0] w_obs;
  assign w_obs = {o_mem_req, o_mem_we, o_mar_we, o_mar_sel, o_ir_we, o_pc_inc, o_pc_load,
                  o_acc_clr, o_acc_inc, o_acc_dec, o_acc_add, o_halted, o_bus_err};

  typedef struct {
    logic [12:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected output vector per stimulated cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, {3'b000, w_obs}, {3'b000, e.exp});
      end
    end
  end

  task automatic step(input logic [2:0] op, input logic z, input logic ack,
                      input logic [12:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    i_opcode  = op;
    i_z_flag  = z;
    i_mem_ack = ack;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    i_mem_ack = 1'b0;
    e.exp = E_NONE; e.name = "rst_active";
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    e.exp = E_NONE; e.name = "s_reset";
    sb_q.push_back(e);
  endtask

  // Opcode is driven to HALT during fetch: outputs must not depend on it there.
  task automatic fetch(input int nwait);
    step(OP_HALT, 1'b0, 1'b0, E_MAR_WE, "faddr");
    for (int i = 0; i < nwait; i++) step(OP_HALT, 1'b0, 1'b0, E_MEM_REQ, "fmem_wait");
    step(OP_HALT, 1'b0, 1'b1, E_MEM_REQ | E_IR_WE | E_PC_INC, "fmem_ack");
  endtask

  task automatic mem_phase(input logic [2:0] op, input int nwait);
    logic [12:0] base;
    logic [12:0] fin;
    base = (op == OP_STA) ? (E_MEM_REQ | E_MEM_WE) : E_MEM_REQ;
    fin  = (op == OP_STA) ? base : (base | E_ACC_ADD);
    for (int i = 0; i < nwait; i++) step(op, 1'b0, 1'b0, base, "data_wait");
    step(op, 1'b0, 1'b1, fin, "data_ack");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    i_opcode  = 3'b000;
    i_z_flag  = 1'b0;
    i_mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // INC 0x20, zero wait: FADDR, FMEM(ack), DECODE, then next FADDR
    fetch(0);
    step(OP_INC, 1'b0, 1'b0, E_ACC_INC, "inc_decode");

    // ADD 0x45, ack delayed 3 cycles
    fetch(0);
    step(OP_ADD, 1'b0, 1'b0, E_MAR_WE | E_MAR_SEL, "add_decode");
    mem_phase(OP_ADD, 3);

    // BNZ 0xA7 with z=0 then z=1
    fetch(1);
    step(OP_BNZ, 1'b0, 1'b0, E_PC_LOAD, "bnz_taken");
    fetch(0);
    step(OP_BNZ, 1'b1, 1'b0, E_NONE, "bnz_not_taken");

    // Remaining single-cycle ops
    fetch(2);
    step(OP_CLR, 1'b0, 1'b0, E_ACC_CLR, "clr_decode");
    fetch(0);
    step(OP_DEC, 1'b0, 1'b0, E_ACC_DEC, "dec_decode");
    fetch(0);
    step(OP_JMP, 1'b1, 1'b0, E_PC_LOAD, "jmp_decode");

    // STA zero wait, then STA acked exactly on the limit cycle (no error)
    fetch(0);
    step(OP_STA, 1'b0, 1'b0, E_MAR_WE | E_MAR_SEL, "sta_decode");
    mem_phase(OP_STA, 0);
    fetch(0);
    step(OP_STA, 1'b0, 1'b0, E_MAR_WE | E_MAR_SEL, "sta_decode");
    mem_phase(OP_STA, 15);

    // Fetch acked on its limit cycle
    fetch(15);
    step(OP_INC, 1'b0, 1'b0, E_ACC_INC, "inc_after_limit_fetch");

    // STA timeout: 16 request cycles without ack, then sticky bus_err
    fetch(0);
    step(OP_STA, 1'b0, 1'b0, E_MAR_WE | E_MAR_SEL, "sta_decode");
    for (int i = 0; i < 16; i++) step(OP_STA, 1'b0, 1'b0, E_MEM_REQ | E_MEM_WE, "sta_wait_to");
    for (int i = 0; i < 6; i++) step(OP_STA, 1'b0, i[0], E_BUS_ERR, "bus_err_sticky");
    do_reset();

    // Five instructions after reset, then HALT
    fetch(0);
    step(OP_CLR, 1'b0, 1'b0, E_ACC_CLR, "clr_decode");
    fetch(1);
    step(OP_INC, 1'b0, 1'b0, E_ACC_INC, "inc_decode");
    fetch(0);
    step(OP_JMP, 1'b0, 1'b0, E_PC_LOAD, "jmp_decode");
    fetch(0);
    step(OP_ADD, 1'b0, 1'b0, E_MAR_WE | E_MAR_SEL, "add_decode");
    mem_phase(OP_ADD, 0);
    fetch(0);
    step(OP_STA, 1'b0, 1'b0, E_MAR_WE | E_MAR_SEL, "sta_decode");
    mem_phase(OP_STA, 2);
    step(OP_HALT, 1'b0, 1'b0, E_MAR_WE, "faddr");
`ifdef PATP_CU_RETIRE_CNT_EN
    check("retired_cnt_5", o_retired_cnt, 16'd5);
`endif
    step(OP_HALT, 1'b0, 1'b1, E_MEM_REQ | E_IR_WE | E_PC_INC, "fmem_ack");
    step(OP_HALT, 1'b0, 1'b0, E_NONE, "halt_decode");
    for (int i = 0; i < 20; i++)
      step(OP_HALT, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), E_HALTED, "halted_hold");
`ifdef PATP_CU_RETIRE_CNT_EN
    check("retired_cnt_halt", o_retired_cnt, 16'd6);
`endif
    do_reset();
`ifdef PATP_CU_RETIRE_CNT_EN
    check("retired_cnt_reset", o_retired_cnt, 16'd0);
`endif
    fetch(0);
    step(OP_INC, 1'b0, 1'b0, E_ACC_INC, "inc_after_halt_reset");

    // Reset during an FMEM wait: mem_req drops without a clock edge, no ir_we
    step(OP_HALT, 1'b0, 1'b0, E_MAR_WE, "faddr");
    step(OP_HALT, 1'b0, 1'b0, E_MEM_REQ, "fmem_wait");
    @(negedge clk);
    #1;
    check("mem_req_before_rst", {15'd0, o_mem_req}, 16'd1);
    rst = 1'b1;
    #1;
    check("mem_req_async_drop", {15'd0, o_mem_req}, 16'd0);
    i_mem_ack = 1'b1;
    #1;
    check("no_ir_we_in_rst", {15'd0, o_ir_we}, 16'd0);
    @(posedge clk);
    #1;
    check("no_ir_we_after_edge", {3'd0, w_obs}, 16'd0);
    rst       = 1'b0;
    i_mem_ack = 1'b0;
    begin
      exp_t e;
      e.exp = E_NONE; e.name = "s_reset_after_mid_rst";
      sb_q.push_back(e);
    end
    fetch(0);
    step(OP_DEC, 1'b0, 1'b0, E_ACC_DEC, "dec_after_mid_rst");

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 5; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    check("scoreboard_drained", 16'(sb_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
